// File: rtl/y86_pkg.sv
// y86_pkg: shared definitions for the sequential Y86 stage controller.
//   - icode constants for the Y86 instruction set
//   - processor status codes (stat_t)
//   - controller FSM state enumeration (state_t)
//   - is_mem_class(): which icodes use the data-memory stage
package y86_pkg;

  localparam logic [3:0] ICODE_HALT  = 4'h0;
  localparam logic [3:0] ICODE_NOP   = 4'h1;
  localparam logic [3:0] ICODE_CMOV  = 4'h2;
  localparam logic [3:0] ICODE_IRMOV = 4'h3;
  localparam logic [3:0] ICODE_RMMOV = 4'h4;
  localparam logic [3:0] ICODE_MRMOV = 4'h5;
  localparam logic [3:0] ICODE_OP    = 4'h6;
  localparam logic [3:0] ICODE_JXX   = 4'h7;
  localparam logic [3:0] ICODE_CALL  = 4'h8;
  localparam logic [3:0] ICODE_RET   = 4'h9;
  localparam logic [3:0] ICODE_PUSH  = 4'hA;
  localparam logic [3:0] ICODE_POP   = 4'hB;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    MEMORY,
    WRITEBACK,
    PCUPDATE,
    HALT
  } state_t;

  // Instructions that read or write data memory (loads, stores, stack ops).
  function automatic logic is_mem_class(input logic [3:0] icode);
    case (icode)
      ICODE_RMMOV, ICODE_MRMOV, ICODE_CALL,
      ICODE_RET,   ICODE_PUSH,  ICODE_POP: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_stage_controller_if.sv
// seq_stage_controller_if: bundle between the stage controller and the rest
// of the sequential Y86 datapath.
//   Fetch side  : start, icode, instr_valid, imem_error
//   Memory side : mem_req, mem_ack, dmem_error
//   Enables     : fetch_en, decode_en, exec_en, wb_en, pc_en, cc_we
//   Status      : stat, halted, instr_count
//   Debug       : cnt_load / cnt_load_value preload instr_count while IDLE
// modport master is the controller; modport slave is the datapath/environment.
interface seq_stage_controller_if;

  logic        start;
  logic [3:0]  icode;
  logic        instr_valid;
  logic        imem_error;
  logic        mem_ack;
  logic        dmem_error;
  logic        cnt_load;
  logic [31:0] cnt_load_value;

  logic        fetch_en;
  logic        decode_en;
  logic        exec_en;
  logic        wb_en;
  logic        pc_en;
  logic        mem_req;
  logic        cc_we;
  logic [2:0]  stat;
  logic        halted;
  logic [31:0] instr_count;

  modport master (
    input  start, icode, instr_valid, imem_error, mem_ack, dmem_error,
           cnt_load, cnt_load_value,
    output fetch_en, decode_en, exec_en, wb_en, pc_en, mem_req, cc_we,
           stat, halted, instr_count
  );

  modport slave (
    output start, icode, instr_valid, imem_error, mem_ack, dmem_error,
           cnt_load, cnt_load_value,
    input  fetch_en, decode_en, exec_en, wb_en, pc_en, mem_req, cc_we,
           stat, halted, instr_count
  );

endinterface

// File: rtl/seq_stage_controller.sv
// seq_stage_controller: sequences one Y86 instruction at a time through
// FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPDATE, raising one stage
// enable per state. Fetch or data-memory faults and the halt instruction
// park the FSM in HALT with the matching status until reset.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - seq_stage_controller_if.master (handshakes, enables, status)
// All outputs are registered: each is computed from the next state so it is
// valid for the whole cycle spent in that state.
module seq_stage_controller
  import y86_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  seq_stage_controller_if.master bus
);

  state_t      state_q, state_d;
  stat_t       stat_q, stat_d;
  logic        halted_q;
  logic        fetch_en_q, decode_en_q, exec_en_q, wb_en_q, pc_en_q;
  logic        mem_req_q, cc_we_q;
  logic [31:0] instr_count_q;

  // Next-state and next-status selection.
  always_comb begin
    state_d = state_q;
    stat_d  = STAT_AOK;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = FETCH;
      end
      FETCH: begin
        // Address fault outranks an illegal encoding, which outranks halt.
        if (bus.imem_error) begin
          state_d = HALT;
          stat_d  = STAT_ADR;
        end else if (!bus.instr_valid) begin
          state_d = HALT;
          stat_d  = STAT_INS;
        end else if (bus.icode == ICODE_HALT) begin
          state_d = HALT;
          stat_d  = STAT_HLT;
        end else begin
          state_d = DECODE;
        end
      end
      DECODE:  state_d = EXECUTE;
      EXECUTE: state_d = MEMORY;
      MEMORY: begin
        // Non-memory instructions pass straight through; memory-class ones
        // wait on mem_ack, and dmem_error only counts alongside that ack.
        if (!is_mem_class(bus.icode)) begin
          state_d = WRITEBACK;
        end else if (bus.mem_ack) begin
          if (bus.dmem_error) begin
            state_d = HALT;
            stat_d  = STAT_ADR;
          end else begin
            state_d = WRITEBACK;
          end
        end
      end
      WRITEBACK: state_d = PCUPDATE;
      PCUPDATE:  state_d = FETCH;
      HALT: begin
        state_d = HALT;
        stat_d  = stat_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      stat_q        <= STAT_AOK;
      halted_q      <= 1'b0;
      fetch_en_q    <= 1'b0;
      decode_en_q   <= 1'b0;
      exec_en_q     <= 1'b0;
      wb_en_q       <= 1'b0;
      pc_en_q       <= 1'b0;
      mem_req_q     <= 1'b0;
      cc_we_q       <= 1'b0;
      instr_count_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      stat_q      <= stat_d;
      halted_q    <= (state_d == HALT);
      fetch_en_q  <= (state_d == FETCH);
      decode_en_q <= (state_d == DECODE);
      exec_en_q   <= (state_d == EXECUTE);
      wb_en_q     <= (state_d == WRITEBACK);
      pc_en_q     <= (state_d == PCUPDATE);
      // icode is already stable when entering EXECUTE/MEMORY, so it can
      // qualify these enables one cycle ahead.
      mem_req_q   <= (state_d == MEMORY) && is_mem_class(bus.icode);
      cc_we_q     <= (state_d == EXECUTE) && (bus.icode == ICODE_OP);
      if (state_q == PCUPDATE) begin
        instr_count_q <= instr_count_q + 32'd1;
      end else if ((state_q == IDLE) && bus.cnt_load) begin
        instr_count_q <= bus.cnt_load_value;
      end
    end
  end

  assign bus.fetch_en    = fetch_en_q;
  assign bus.decode_en   = decode_en_q;
  assign bus.exec_en     = exec_en_q;
  assign bus.wb_en       = wb_en_q;
  assign bus.pc_en       = pc_en_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.cc_we       = cc_we_q;
  assign bus.stat        = stat_q;
  assign bus.halted      = halted_q;
  assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_seq_stage_controller.sv
// tb_seq_stage_controller: self-checking bench for seq_stage_controller.
// A per-instruction timeline model builds the expected enable/status trace
// for each instruction from the instruction-level rules, and every cycle the
// DUT outputs are compared with it on the falling clock edge.
module tb_seq_stage_controller;

  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] HLT = 3'd2;
  localparam logic [2:0] ADR = 3'd3;
  localparam logic [2:0] INS = 3'd4;

  // Enable vectors ordered {fetch, decode, exec, mem_req, wb, pc}.
  localparam logic [5:0] EN_F = 6'b100000;
  localparam logic [5:0] EN_D = 6'b010000;
  localparam logic [5:0] EN_E = 6'b001000;
  localparam logic [5:0] EN_M = 6'b000100;
  localparam logic [5:0] EN_W = 6'b000010;
  localparam logic [5:0] EN_P = 6'b000001;
  localparam logic [5:0] EN_0 = 6'b000000;

  typedef struct packed {
    logic [5:0] en;
    logic       cc;
    logic       fetch;
    logic       ack;
    logic       derr;
  } cyc_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] exp_count;
  logic [2:0]  exp_stat;
  logic        exp_halted;

  seq_stage_controller_if bus();

  seq_stage_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic cyc_t mk(input logic [5:0] en, input logic cc, input logic f,
                              input logic ack, input logic derr);
    cyc_t c;
    c.en = en; c.cc = cc; c.fetch = f; c.ack = ack; c.derr = derr;
    return c;
  endfunction

  function automatic logic [42:0] pack_obs(input logic [5:0] en, input logic cc,
                                           input logic h, input logic [2:0] st,
                                           input logic [31:0] cnt);
    return {en, cc, h, st, cnt};
  endfunction

  function automatic logic [42:0] obs();
    return pack_obs({bus.fetch_en, bus.decode_en, bus.exec_en, bus.mem_req,
                     bus.wb_en, bus.pc_en}, bus.cc_we, bus.halted, bus.stat,
                    bus.instr_count);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.cnt_load = 1'b0; bus.cnt_load_value = 32'd0;
    bus.mem_ack = 1'b0; bus.dmem_error = 1'b0;
    bus.imem_error = 1'b0; bus.instr_valid = 1'b0; bus.icode = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 32'd0; exp_stat = AOK; exp_halted = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Runs one instruction from its FETCH cycle. d = wait cycles before mem_ack
  // for memory-class icodes. abort_at >= 0 pulses rst_n low during that cycle.
  task automatic run_instr(input string tag, input logic [3:0] c, input logic v,
                           input logic e, input int d, input logic de,
                           input int abort_at);
    cyc_t q[$];
    logic halts;
    logic [2:0] hstat;
    logic mem;
    logic aborted;
    mem = (c inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB});
    halts = 1'b0;
    hstat = AOK;
    aborted = 1'b0;
    q.push_back(mk(EN_F, 1'b0, 1'b1, rbit(), rbit()));
    if (e) begin
      halts = 1'b1; hstat = ADR;
    end else if (!v) begin
      halts = 1'b1; hstat = INS;
    end else if (c == 4'h0) begin
      halts = 1'b1; hstat = HLT;
    end else begin
      q.push_back(mk(EN_D, 1'b0, 1'b0, rbit(), rbit()));
      q.push_back(mk(EN_E, c == 4'h6, 1'b0, rbit(), rbit()));
      if (mem) begin
        for (int i = 0; i <= d; i++)
          q.push_back(mk(EN_M, 1'b0, 1'b0, i == d, (i == d) ? de : rbit()));
      end else begin
        q.push_back(mk(EN_0, 1'b0, 1'b0, rbit(), rbit()));
      end
      if (mem && de) begin
        halts = 1'b1; hstat = ADR;
      end else begin
        q.push_back(mk(EN_W, 1'b0, 1'b0, rbit(), rbit()));
        q.push_back(mk(EN_P, 1'b0, 1'b0, rbit(), rbit()));
      end
    end
    for (int k = 0; k < q.size(); k++) begin
      checks++;
      if (obs() !== pack_obs(q[k].en, q[k].cc, 1'b0, AOK, exp_count)) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h want %h", tag, k, obs(),
                 pack_obs(q[k].en, q[k].cc, 1'b0, AOK, exp_count));
      end
      bus.icode       = c;
      bus.instr_valid = q[k].fetch ? v : rbit();
      bus.imem_error  = q[k].fetch ? e : rbit();
      bus.mem_ack     = q[k].ack;
      bus.dmem_error  = q[k].derr;
      bus.start       = rbit();
      if (k == abort_at) begin
        bus.start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== pack_obs(EN_0, 1'b0, 1'b0, AOK, 32'd0)) begin
          errors++;
          $display("FAIL %s async_reset: got %h want %h", tag, obs(),
                   pack_obs(EN_0, 1'b0, 1'b0, AOK, 32'd0));
        end
        rst_n = 1'b1;
        bus.mem_ack = 1'b0;
        exp_count = 32'd0; exp_stat = AOK; exp_halted = 1'b0;
        aborted = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    if (!aborted) begin
      if (halts) begin
        exp_halted = 1'b1; exp_stat = hstat;
      end else begin
        exp_count = exp_count + 32'd1;
      end
    end
  endtask

  task automatic halt_absorb(input string tag);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs() !== pack_obs(EN_0, 1'b0, 1'b1, exp_stat, exp_count)) begin
        errors++;
        $display("FAIL %s halt_hold %0d: got %h want %h", tag, i, obs(),
                 pack_obs(EN_0, 1'b0, 1'b1, exp_stat, exp_count));
      end
      bus.start = 1'b1;
      bus.instr_valid = rbit(); bus.imem_error = rbit();
      bus.mem_ack = rbit(); bus.dmem_error = rbit();
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  task automatic idle_hold(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs() !== pack_obs(EN_0, 1'b0, 1'b0, AOK, exp_count)) begin
        errors++;
        $display("FAIL %s idle %0d: got %h want %h", tag, i, obs(),
                 pack_obs(EN_0, 1'b0, 1'b0, AOK, exp_count));
      end
      bus.start = 1'b0;
      bus.icode = 4'($urandom_range(0, 15));
      bus.instr_valid = rbit(); bus.imem_error = rbit();
      bus.mem_ack = rbit(); bus.dmem_error = rbit();
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.cnt_load = 1'b0; bus.cnt_load_value = 32'd0;
    bus.mem_ack = 1'b0; bus.dmem_error = 1'b0;
    bus.imem_error = 1'b0; bus.instr_valid = 1'b0; bus.icode = 4'h0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== pack_obs(EN_0, 1'b0, 1'b0, AOK, 32'd0)) begin
      errors++;
      $display("FAIL reset_values: got %h want %h", obs(),
               pack_obs(EN_0, 1'b0, 1'b0, AOK, 32'd0));
    end
    rst_n = 1'b1;
    exp_count = 32'd0; exp_stat = AOK; exp_halted = 1'b0;
    @(negedge clk);
    idle_hold("reset", 3);
  endtask

  task automatic test_opq();
    start_pulse();
    run_instr("opq", 4'h6, 1'b1, 1'b0, 0, 1'b0, -1);
    checks++;
    if (bus.instr_count !== 32'd1 || bus.fetch_en !== 1'b1) begin
      errors++;
      $display("FAIL opq_retire: count %h fetch %b want 1 and 1",
               bus.instr_count, bus.fetch_en);
    end
  endtask

  task automatic test_mem_wait();
    run_instr("mrmov_wait3", 4'h5, 1'b1, 1'b0, 3, 1'b0, -1);
    checks++;
    if (bus.instr_count !== 32'd2 || bus.fetch_en !== 1'b1) begin
      errors++;
      $display("FAIL mrmov_retire: count %h fetch %b want 2 and 1",
               bus.instr_count, bus.fetch_en);
    end
  endtask

  task automatic test_random_stream();
    for (int n = 0; n < 30; n++)
      run_instr("random", 4'($urandom_range(1, 11)), 1'b1, 1'b0,
                int'($urandom_range(0, 4)), 1'b0, -1);
  endtask

  task automatic test_dmem_error();
    run_instr("push_derr", 4'hA, 1'b1, 1'b0, int'($urandom_range(0, 3)), 1'b1, -1);
    halt_absorb("push_derr");
  endtask

  task automatic test_reset_mid_memory();
    do_reset();
    start_pulse();
    run_instr("call_abort", 4'h8, 1'b1, 1'b0, 4, 1'b0, 4);
    idle_hold("after_abort", 3);
    start_pulse();
    run_instr("nop_after_abort", 4'h1, 1'b1, 1'b0, 0, 1'b0, -1);
  endtask

  task automatic test_fetch_errors();
    run_instr("imem_err", 4'($urandom_range(0, 15)), 1'b0, 1'b1, 0, 1'b0, -1);
    halt_absorb("imem_err");
    do_reset();
    start_pulse();
    run_instr("ins", 4'($urandom_range(1, 15)), 1'b0, 1'b0, 0, 1'b0, -1);
    halt_absorb("ins");
    do_reset();
    start_pulse();
    run_instr("nop_then_halt", 4'h1, 1'b1, 1'b0, 0, 1'b0, -1);
    run_instr("halt", 4'h0, 1'b1, 1'b0, 0, 1'b0, -1);
    halt_absorb("halt");
  endtask

  task automatic test_wrap();
    do_reset();
    bus.cnt_load = 1'b1;
    bus.cnt_load_value = 32'hFFFF_FFFE;
    @(negedge clk);
    bus.cnt_load = 1'b0;
    exp_count = 32'hFFFF_FFFE;
    idle_hold("preload", 1);
    start_pulse();
    run_instr("wrap_nop1", 4'h1, 1'b1, 1'b0, 0, 1'b0, -1);
    run_instr("wrap_nop2", 4'h1, 1'b1, 1'b0, 0, 1'b0, -1);
    checks++;
    if (obs() !== pack_obs(EN_F, 1'b0, 1'b0, AOK, 32'h0000_0000)) begin
      errors++;
      $display("FAIL wrap_zero: got %h want %h", obs(),
               pack_obs(EN_F, 1'b0, 1'b0, AOK, 32'h0000_0000));
    end
  endtask

  initial begin
    test_reset();
    test_opq();
    test_mem_wait();
    test_random_stream();
    test_dmem_error();
    test_reset_mid_memory();
    do_reset();
    start_pulse();
    test_fetch_errors();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
